nios2_dbg_cmd_bridge: RTL and testbench
=======================================

// Module: nios2_dbg_cmd_bridge
// PURPOSE
//  System-clock half of the OCI debug-slave path, generalised. Synchronises JTAG
//  update-DR/update-IR strobes into clk. Captures the quasi-static shift register,
//  IR and channel select into a command FIFO. Issues per-channel, per-IR one-hot
//  action/no-action strobes as commands drain, so several debug targets share one
//  virtual-JTAG node.
// PARAMETERS
//  DATA_W      38  width of shift register / jdo
//  IR_W        2   virtual IR width; 2**IR_W codes per channel
//  NUM_CH      2   debug channels (targets) behind this node; CH_W=max(1,$clog2(NUM_CH))
//  FIFO_DEPTH  4   command entries, power of 2, >=2
//  SYNC_STAGES 2   synchroniser flops for vs_udr/vs_uir, >=2
//  ACT_BIT     34  sr bit that selects take_action (1) vs take_no_action (0)
// PORTS
//  clk             in   1                    system clock
//  reset_n         in   1                    async active-low reset
//  vs_udr          in   1                    update-DR level from tck domain (async)
//  vs_uir          in   1                    update-IR level from tck domain (async)
//  sr              in   DATA_W               shift register, stable while vs_udr high
//  ir_in           in   IR_W                 virtual IR, stable while vs_udr high
//  ch_sel          in   CH_W                 target channel, stable while vs_udr high
//  cmd_ready       in   1                    consumer accepts head command
//  ovf_clr         in   1                    clears overflow flag
//  cmd_valid       out  1                    FIFO head valid
//  cmd_ch          out  CH_W                 head channel
//  cmd_ir          out  IR_W                 head IR
//  jdo             out  DATA_W               data of last accepted command (held)
//  take_action     out  NUM_CH*2**IR_W       one-hot pulse, index ch*2**IR_W+ir
//  take_no_action  out  NUM_CH*2**IR_W       one-hot pulse, same indexing
//  ir_update       out  1                    1-cycle pulse per synced vs_uir rise
//  fifo_level      out  $clog2(FIFO_DEPTH)+1 current occupancy
//  overflow        out  1                    sticky: capture dropped while full
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops 0; FIFO pointers 0; capture FSM = ARM.
//  - vs_udr, vs_uir pass through SYNC_STAGES flops each. Rise = synced 1, prev 0.
//  - Capture FSM:
//    ARM: wait for synced vs_udr==0, then IDLE. A level held high across reset
//      release never makes a command.
//    IDLE: udr rise -> CAPT.
//    CAPT: one cycle; push {ch_sel,ir_in,sr} -> IDLE.
//  - Latency: raw vs_udr rise -> push at cycle SYNC_STAGES+2 -> cmd_valid next cycle.
//  - Push while full with no pop in that cycle: entry dropped, overflow<=1.
//    Full + pop in the same cycle: push accepted, level unchanged.
//  - ch_sel >= NUM_CH: entry dropped, overflow<=1.
//  - Handshake: accept = cmd_valid & cmd_ready; cmd_ch/cmd_ir show head, combinational
//    from FIFO RAM. Empty: cmd_valid=0, cmd_ready ignored.
//  - On accept, registered, visible the next cycle for exactly 1 cycle:
//    jdo <= head data; take_action[idx] if data[ACT_BIT] else take_no_action[idx];
//    at most one strobe bit high per cycle. jdo holds until the next accept.
//  - Back-to-back accepts give consecutive single-cycle strobes.
//  - ir_update: registered pulse one cycle after synced vs_uir rise; no FIFO effect.
//    Handled independently of udr: simultaneous rises do both.
//  - overflow: set wins over ovf_clr in the same cycle.
//  - fifo_level: counts pushes minus pops, saturates at FIFO_DEPTH, never wraps.
//  - Async reset mid-operation: FIFO emptied, in-flight strobes dropped, FSM -> ARM.
// STRUCTURE
//  - Package nios2_dbg_pkg: cmd_t struct {ch,ir,data}; localparams CH_W, NUM_ACT;
//    function act_idx(ch,ir).
//  - Sub-module nios2_dbg_cmd_fifo: FIFO_DEPTH x cmd_t; push/pop, full/empty, level;
//    async reset.
//  - Synchronisers, capture FSM, strobe decode and jdo register stay in this module.
// TESTING
//  - Reset with vs_udr=1 held, release, hold 10 clk -> no push.
//    Drop vs_udr then raise it -> exactly 1 command.
//  - ch=1, ir=2, sr[34]=1, sr=38'h4_0000_00AB, cmd_ready=1 ->
//    take_action[6] single pulse; jdo=38'h4_0000_00AB; fifo_level back to 0.
//  - sr[34]=0, ch=0, ir=3 -> take_no_action[3] pulse; take_action stays 0.
//  - cmd_ready=0, 5 udr events (DEPTH=4) -> level=4, overflow=1, first 4 drain in
//    order; ovf_clr -> overflow=0.
//  - Full FIFO: push and pop in the same cycle -> level stays 4; overflow stays 0.
//  - Simultaneous vs_uir and vs_udr rises -> ir_update pulse and one push, same cycle.
//  - Assert reset_n low mid-drain -> all strobes 0 immediately; level 0; FSM ARM.

Source files
------------

// File: rtl/nios2_dbg_cmd_bridge_pkg.sv
// Shared types, widths and index helper for the system-clock half of the debug command path.
// Widths here fix the command word layout used by the FIFO and the bridge interface.
package nios2_dbg_pkg;

   localparam int DATA_W     = 38;
   localparam int IR_W       = 2;
   localparam int NUM_CH     = 2;
   localparam int FIFO_DEPTH = 4;

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NUM_IR  = 2 ** IR_W;
   localparam int NUM_ACT = NUM_CH * NUM_IR;
   localparam int IDX_W   = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1;
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      CAPT = 2'd2
   } capState_e;

   // NUM_IR is a power of two, so ch*NUM_IR+ir is just the concatenation
   function automatic logic [IDX_W-1:0] act_idx(input logic [CH_W-1:0] ch,
                                                input logic [IR_W-1:0] ir);
      act_idx = IDX_W'({ch, ir});
   endfunction

endpackage

// File: rtl/nios2_dbg_cmd_bridge_if.sv
// Bundle of tck-side capture inputs, command handshake and strobe outputs of the bridge.
// The bridge takes the slave view; whoever drives JTAG updates and consumes commands takes master.
interface nios2_dbg_cmd_bridge_if;
   import nios2_dbg_pkg::*;

   logic                vs_udr;
   logic                vs_uir;
   logic [DATA_W-1:0]   sr;
   logic [IR_W-1:0]     ir_in;
   logic [CH_W-1:0]     ch_sel;
   logic                cmd_ready;
   logic                ovf_clr;

   logic                cmd_valid;
   logic [CH_W-1:0]     cmd_ch;
   logic [IR_W-1:0]     cmd_ir;
   logic [DATA_W-1:0]   jdo;
   logic [NUM_ACT-1:0]  take_action;
   logic [NUM_ACT-1:0]  take_no_action;
   logic                ir_update;
   logic [LVL_W-1:0]    fifo_level;
   logic                overflow;

   modport master (
      output vs_udr, vs_uir, sr, ir_in, ch_sel, cmd_ready, ovf_clr,
      input  cmd_valid, cmd_ch, cmd_ir, jdo, take_action, take_no_action,
             ir_update, fifo_level, overflow
   );

   modport slave (
      input  vs_udr, vs_uir, sr, ir_in, ch_sel, cmd_ready, ovf_clr,
      output cmd_valid, cmd_ch, cmd_ir, jdo, take_action, take_no_action,
             ir_update, fifo_level, overflow
   );

endinterface

// File: rtl/nios2_dbg_cmd_bridge_fifo.sv
// Small circular command FIFO; a push into a full FIFO succeeds only if a pop frees a slot that cycle.
// Read data is the head entry, combinational from storage, forced to zero while empty.
module nios2_dbg_cmd_fifo
   import nios2_dbg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  cmd_t                       wdata_i,
   input  logic                       pop_i,
   output cmd_t                       rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LW    = PTR_W + 1;

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign doPop   = pop_i & ~empty_o;
   assign doPush  = push_i & (~full_o | doPop);
   assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];
   assign level_o = level_q;

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/nios2_dbg_cmd_bridge.sv
// Synchronises JTAG update strobes into clk, queues captured commands and turns each drained
// command into a one-cycle per-channel/per-IR action or no-action strobe plus a held jdo word.
module nios2_dbg_cmd_bridge
   import nios2_dbg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ACT_BIT     = 34
) (
   input  logic                   clk,
   input  logic                   reset_n,
   nios2_dbg_cmd_bridge_if.slave  dbg
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] udrSync_q;
   logic [SYNC_STAGES-1:0] uirSync_q;
   logic                   udrPrev_q;
   logic                   uirPrev_q;
   logic                   udrSynced;
   logic                   uirSynced;
   logic                   udrRise;
   logic                   uirRise;

   capState_e              state_q, state_d;
   logic [ARM_W-1:0]       armCnt_q, armCnt_d;
   logic                   armDone;
   logic                   capPush;
   logic                   chValid;

   cmd_t                   wrCmd;
   cmd_t                   head;
   logic                   fifoFull;
   logic                   fifoEmpty;
   logic                   accept;
   logic [LVL_W-1:0]       level;
   logic [IDX_W-1:0]       headIdx;

   logic [DATA_W-1:0]      jdo_q, jdo_d;
   logic [NUM_ACT-1:0]     act_q, act_d;
   logic [NUM_ACT-1:0]     noAct_q, noAct_d;
   logic                   overflow_q, overflow_d;
   logic                   irUpdate_q;

   assign udrSynced = udrSync_q[SYNC_STAGES-1];
   assign uirSynced = uirSync_q[SYNC_STAGES-1];
   assign udrRise   = udrSynced & ~udrPrev_q;
   assign uirRise   = uirSynced & ~uirPrev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udrSync_q  <= '0;
         uirSync_q  <= '0;
         udrPrev_q  <= 1'b0;
         uirPrev_q  <= 1'b0;
         irUpdate_q <= 1'b0;
      end else begin
         udrSync_q  <= {udrSync_q[SYNC_STAGES-2:0], dbg.vs_udr};
         uirSync_q  <= {uirSync_q[SYNC_STAGES-2:0], dbg.vs_uir};
         udrPrev_q  <= udrSynced;
         uirPrev_q  <= uirSynced;
         irUpdate_q <= uirRise;
      end
   end

   // Synchroniser flops read 0 straight after reset, so ARM only trusts the synced level
   // once the chain has been refilled from the real input.
   assign armDone = (armCnt_q == ARM_W'(SYNC_STAGES));

   always_comb begin
      state_d  = state_q;
      armCnt_d = armCnt_q;
      capPush  = 1'b0;
      case (state_q)
         ARM: begin
            if (!armDone) begin
               armCnt_d = armCnt_q + ARM_W'(1);
            end else if (!udrSynced) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (udrRise) begin
               state_d = CAPT;
            end
         end
         CAPT: begin
            capPush = 1'b1;
            state_d = IDLE;
         end
         default: state_d = ARM;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ARM;
         armCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         armCnt_q <= armCnt_d;
      end
   end

   generate
      if (NUM_CH == (2 ** CH_W)) begin : g_chAll
         assign chValid = 1'b1;
      end else begin : g_chCmp
         assign chValid = ({1'b0, dbg.ch_sel} < (CH_W + 1)'(NUM_CH));
      end
   endgenerate

   assign wrCmd  = '{ch: dbg.ch_sel, ir: dbg.ir_in, data: dbg.sr};
   assign accept = ~fifoEmpty & dbg.cmd_ready;

   nios2_dbg_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (capPush & chValid),
      .wdata_i (wrCmd),
      .pop_i   (accept),
      .rdata_o (head),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .level_o (level)
   );

   assign headIdx = act_idx(head.ch, head.ir);

   // A set in the same cycle as ovf_clr must survive, hence the set is applied last.
   always_comb begin
      jdo_d      = jdo_q;
      act_d      = '0;
      noAct_d    = '0;
      overflow_d = overflow_q;
      if (accept) begin
         jdo_d = head.data;
         if (head.data[ACT_BIT]) begin
            act_d[headIdx] = 1'b1;
         end else begin
            noAct_d[headIdx] = 1'b1;
         end
      end
      if (dbg.ovf_clr) begin
         overflow_d = 1'b0;
      end
      if (capPush && (!chValid || (fifoFull && !accept))) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo_q      <= '0;
         act_q      <= '0;
         noAct_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         jdo_q      <= jdo_d;
         act_q      <= act_d;
         noAct_q    <= noAct_d;
         overflow_q <= overflow_d;
      end
   end

   assign dbg.cmd_valid      = ~fifoEmpty;
   assign dbg.cmd_ch         = head.ch;
   assign dbg.cmd_ir         = head.ir;
   assign dbg.jdo            = jdo_q;
   assign dbg.take_action    = act_q;
   assign dbg.take_no_action = noAct_q;
   assign dbg.ir_update      = irUpdate_q;
   assign dbg.fifo_level     = level;
   assign dbg.overflow       = overflow_q;

endmodule

// File: tb/tb_nios2_dbg_cmd_bridge.sv
// Directed bench for the debug command bridge: stimulus pushes expected heads/strobes into queues,
// a negedge monitor pops and compares them whenever the bridge accepts a command or strobes.
module tb_nios2_dbg_cmd_bridge;
   import nios2_dbg_pkg::*;

   typedef struct {
      logic              act;
      int                idx;
      logic [DATA_W-1:0] data;
   } strobeExp_t;

   logic clk;
   logic reset_n;
   int   errors;
   int   checks;

   strobeExp_t                 strobeQ [$];
   logic [CH_W+IR_W-1:0]       headQ   [$];

   logic [CH_W-1:0]   tabCh   [5];
   logic [IR_W-1:0]   tabIr   [5];
   logic [DATA_W-1:0] tabData [5];
   int                tabIdx  [5];

   nios2_dbg_cmd_bridge_if dbg ();

   nios2_dbg_cmd_bridge dut (
      .clk     (clk),
      .reset_n (reset_n),
      .dbg     (dbg)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectCmd(input logic [CH_W-1:0] ch, input logic [IR_W-1:0] ir,
                            input logic [DATA_W-1:0] data, input int idx);
      strobeExp_t e;
      e.act  = data[34];
      e.idx  = idx;
      e.data = data;
      strobeQ.push_back(e);
      headQ.push_back({ch, ir});
   endtask

   // One full update-DR pulse; keep=0 means the entry is expected to be dropped
   task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [IR_W-1:0] ir,
                                input logic [DATA_W-1:0] data, input int idx, input bit keep);
      dbg.ch_sel = ch;
      dbg.ir_in  = ir;
      dbg.sr     = data;
      if (keep) expectCmd(ch, ir, data, idx);
      dbg.vs_udr = 1'b1;
      repeat (4) tick();
      dbg.vs_udr = 1'b0;
      repeat (4) tick();
   endtask

   // Scoreboard monitor: head checked on accept, strobe and jdo checked the cycle after
   always @(negedge clk) begin
      strobeExp_t         e;
      logic [NUM_ACT-1:0] expA;
      logic [NUM_ACT-1:0] expN;
      logic [CH_W+IR_W-1:0] h;
      if (reset_n) begin
         if (dbg.cmd_valid && dbg.cmd_ready) begin
            if (headQ.size() == 0) begin
               checkOutput("unexpected_head", 64'(dbg.cmd_valid), 64'd0);
            end else begin
               h = headQ.pop_front();
               checkOutput("head_ch_ir", 64'({dbg.cmd_ch, dbg.cmd_ir}), 64'(h));
            end
         end
         if ((|dbg.take_action) || (|dbg.take_no_action)) begin
            if (strobeQ.size() == 0) begin
               checkOutput("unexpected_strobe",
                           64'({dbg.take_action, dbg.take_no_action}), 64'd0);
            end else begin
               e    = strobeQ.pop_front();
               expA = '0;
               expN = '0;
               if (e.act) expA[e.idx] = 1'b1;
               else       expN[e.idx] = 1'b1;
               checkOutput("take_action", 64'(dbg.take_action), 64'(expA));
               checkOutput("take_no_action", 64'(dbg.take_no_action), 64'(expN));
               checkOutput("jdo_strobe", 64'(dbg.jdo), 64'(e.data));
            end
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      tabCh[0] = 1'b0; tabIr[0] = 2'd0; tabData[0] = 38'h0_0000_0101; tabIdx[0] = 0;
      tabCh[1] = 1'b1; tabIr[1] = 2'd1; tabData[1] = 38'h4_0000_0102; tabIdx[1] = 5;
      tabCh[2] = 1'b0; tabIr[2] = 2'd2; tabData[2] = 38'h4_0000_0103; tabIdx[2] = 2;
      tabCh[3] = 1'b1; tabIr[3] = 2'd3; tabData[3] = 38'h0_0000_0104; tabIdx[3] = 7;
      tabCh[4] = 1'b1; tabIr[4] = 2'd0; tabData[4] = 38'h0_0000_0105; tabIdx[4] = 4;

      // Reset with vs_udr held high
      reset_n       = 1'b0;
      dbg.vs_udr    = 1'b1;
      dbg.vs_uir    = 1'b0;
      dbg.sr        = 38'h0_1234_5678;
      dbg.ir_in     = 2'd1;
      dbg.ch_sel    = 1'b0;
      dbg.cmd_ready = 1'b0;
      dbg.ovf_clr   = 1'b0;
      repeat (3) tick();
      checkOutput("rst_cmd_valid", 64'(dbg.cmd_valid), 64'd0);
      checkOutput("rst_level", 64'(dbg.fifo_level), 64'd0);
      checkOutput("rst_overflow", 64'(dbg.overflow), 64'd0);
      checkOutput("rst_jdo", 64'(dbg.jdo), 64'd0);
      checkOutput("rst_strobes", 64'({dbg.take_action, dbg.take_no_action}), 64'd0);
      checkOutput("rst_ir_update", 64'(dbg.ir_update), 64'd0);

      reset_n = 1'b1;
      repeat (10) tick();
      checkOutput("held_udr_no_push", 64'(dbg.fifo_level), 64'd0);
      checkOutput("held_udr_no_valid", 64'(dbg.cmd_valid), 64'd0);

      dbg.vs_udr = 1'b0;
      repeat (6) tick();
      expectCmd(1'b0, 2'd1, 38'h0_1234_5678, 1);
      dbg.vs_udr = 1'b1;
      repeat (6) tick();
      dbg.vs_udr = 1'b0;
      repeat (3) tick();
      checkOutput("first_cmd_level", 64'(dbg.fifo_level), 64'd1);
      checkOutput("first_cmd_valid", 64'(dbg.cmd_valid), 64'd1);
      dbg.cmd_ready = 1'b1;
      repeat (4) tick();
      checkOutput("first_cmd_drained", 64'(dbg.fifo_level), 64'd0);
      checkOutput("first_cmd_jdo", 64'(dbg.jdo), 64'h0_1234_5678);

      // Action on ch1/ir2 and no-action on ch0/ir3
      applyStimulus(1'b1, 2'd2, 38'h4_0000_00AB, 6, 1'b1);
      checkOutput("act_jdo_held", 64'(dbg.jdo), 64'h4_0000_00AB);
      checkOutput("act_level", 64'(dbg.fifo_level), 64'd0);
      applyStimulus(1'b0, 2'd3, 38'h0_0000_1234, 3, 1'b1);
      checkOutput("noact_jdo_held", 64'(dbg.jdo), 64'h0_0000_1234);
      checkOutput("noact_act_quiet", 64'(dbg.take_action), 64'd0);

      // Five captures into a 4-deep FIFO, then clear and drain in order
      dbg.cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(tabCh[i], tabIr[i], tabData[i], tabIdx[i], i < 4);
      end
      checkOutput("ovf_level", 64'(dbg.fifo_level), 64'd4);
      checkOutput("ovf_set", 64'(dbg.overflow), 64'd1);
      dbg.ovf_clr = 1'b1;
      tick();
      dbg.ovf_clr = 1'b0;
      checkOutput("ovf_cleared", 64'(dbg.overflow), 64'd0);
      dbg.cmd_ready = 1'b1;
      repeat (8) tick();
      checkOutput("ovf_drained", 64'(dbg.fifo_level), 64'd0);

      // Full FIFO with push and pop landing in the same cycle
      dbg.cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(tabCh[i], tabIr[i], tabData[i], tabIdx[i], 1'b1);
      end
      checkOutput("full_level", 64'(dbg.fifo_level), 64'd4);
      dbg.ch_sel = 1'b1;
      dbg.ir_in  = 2'd0;
      dbg.sr     = 38'h4_0000_0105;
      expectCmd(1'b1, 2'd0, 38'h4_0000_0105, 4);
      dbg.vs_udr = 1'b1;
      repeat (3) tick();
      dbg.cmd_ready = 1'b1;
      tick();
      dbg.cmd_ready = 1'b0;
      checkOutput("pushpop_level", 64'(dbg.fifo_level), 64'd4);
      checkOutput("pushpop_no_ovf", 64'(dbg.overflow), 64'd0);
      dbg.vs_udr    = 1'b0;
      dbg.cmd_ready = 1'b1;
      repeat (8) tick();
      checkOutput("pushpop_drained", 64'(dbg.fifo_level), 64'd0);

      // Simultaneous update-IR and update-DR rises
      dbg.cmd_ready = 1'b0;
      dbg.ch_sel    = 1'b0;
      dbg.ir_in     = 2'd2;
      dbg.sr        = 38'h4_0000_0200;
      expectCmd(1'b0, 2'd2, 38'h4_0000_0200, 2);
      dbg.vs_udr = 1'b1;
      dbg.vs_uir = 1'b1;
      repeat (2) tick();
      checkOutput("irupd_early", 64'(dbg.ir_update), 64'd0);
      tick();
      checkOutput("irupd_pulse", 64'(dbg.ir_update), 64'd1);
      checkOutput("irupd_not_yet_valid", 64'(dbg.cmd_valid), 64'd0);
      tick();
      checkOutput("irupd_single", 64'(dbg.ir_update), 64'd0);
      checkOutput("irupd_push_level", 64'(dbg.fifo_level), 64'd1);
      dbg.vs_udr    = 1'b0;
      dbg.vs_uir    = 1'b0;
      dbg.cmd_ready = 1'b1;
      repeat (6) tick();
      checkOutput("irupd_drained", 64'(dbg.fifo_level), 64'd0);

      // Reset asserted mid-drain
      dbg.cmd_ready = 1'b0;
      applyStimulus(1'b0, 2'd0, 38'h0_0000_0301, 0, 1'b1);
      applyStimulus(1'b1, 2'd1, 38'h4_0000_0302, 5, 1'b1);
      applyStimulus(1'b0, 2'd3, 38'h4_0000_0303, 3, 1'b1);
      checkOutput("mid_level", 64'(dbg.fifo_level), 64'd3);
      dbg.cmd_ready = 1'b1;
      repeat (2) tick();
      #1 reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_strobes", 64'({dbg.take_action, dbg.take_no_action}), 64'd0);
      checkOutput("mid_rst_level", 64'(dbg.fifo_level), 64'd0);
      checkOutput("mid_rst_valid", 64'(dbg.cmd_valid), 64'd0);
      checkOutput("mid_rst_jdo", 64'(dbg.jdo), 64'd0);
      headQ.delete();
      strobeQ.delete();
      dbg.cmd_ready = 1'b0;
      tick();
      reset_n       = 1'b1;
      dbg.cmd_ready = 1'b1;
      repeat (5) tick();
      applyStimulus(1'b1, 2'd3, 38'h4_0000_0ABC, 7, 1'b1);
      checkOutput("post_rst_jdo", 64'(dbg.jdo), 64'h4_0000_0ABC);

      checkOutput("head_queue_empty", 64'(headQ.size()), 64'd0);
      checkOutput("strobe_queue_empty", 64'(strobeQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
